// File: rtl/fp_round_pkg.sv
// fp_round_pkg: shared types and constants for the FP round/pack stage.
package fp_round_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam int unsigned FFLAG_NX = 0;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_NV = 4;

  localparam logic [31:0] FP32_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_MAX = 32'h7F7F_FFFF;

  // Width-independent part of an incoming beat
  typedef struct packed {
    logic        sign;
    logic [2:0]  grs;
    logic [2:0]  rm;
    logic        special;
    logic        special_nv;
    logic [31:0] special_val;
  } ctrl_t;

endpackage

// File: rtl/round_incr_fp.sv
// round_incr_fp: round-up decision and inexact detection from sign, lsb, GRS and rm.
// Reserved rm encodings behave as round-to-nearest-even.
module round_incr_fp
  import fp_round_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic [2:0] grs,
  input  logic [2:0] rm,
  output logic       inc,
  output logic       inexact
);

  // Increment decision per rounding mode
  always_comb begin
    inexact = |grs;
    inc     = 1'b0;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = ~sign & inexact;
      RM_RMM:  inc = grs[2];
      default: inc = grs[2] & (grs[1] | grs[0] | lsb);
    endcase
  end

endmodule

// File: rtl/round_pack_fp_r4.sv
// round_pack_fp_r4: applies rounding to a normalized FP add/sub result, renormalizes on
// mantissa carry, handles overflow/underflow and packs binary32 plus fflags.
// Two registered stages (capture, pack) with a valid/ready chain.
// Optional FP_ROUND_SKID_EN: one-entry input skid so in_ready comes from a flop.
module round_pack_fp_r4
  import fp_round_pkg::*;
#(
  parameter int unsigned MAN_W   = 23,
  parameter int unsigned EXP_W   = 10,
  parameter int unsigned EXP_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [MAN_W-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [2:0]       in_grs,
  input  logic             in_underflow,
  input  logic [2:0]       in_rm,
  input  logic             in_special,
  input  logic [31:0]      in_special_val,
  input  logic             in_special_nv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_fflags
);

  localparam int unsigned PEXP_W = 31 - MAN_W;
  localparam int unsigned XE_W   = EXP_W + 1;

  // Underflow is decided after rounding, so the normalizer's hint is not needed
  logic unused_in_underflow;
  assign unused_in_underflow = in_underflow;

  ctrl_t            in_ctrl;
  logic             s1_valid, s1_adv, s2_adv, accept, src_valid;
  logic [MAN_W-1:0] src_mant, s1_mant;
  logic [EXP_W-1:0] src_exp, s1_exp;
  ctrl_t            src_ctrl, s1_ctrl;

  assign in_ctrl = '{sign: in_sign, grs: in_grs, rm: in_rm, special: in_special,
                     special_nv: in_special_nv, special_val: in_special_val};

  assign s2_adv = ~out_valid | out_ready;
  assign s1_adv = ~s1_valid | s2_adv;

`ifdef FP_ROUND_SKID_EN
  logic             skid_valid, skid_valid_nxt, in_ready_q;
  logic [MAN_W-1:0] skid_mant;
  logic [EXP_W-1:0] skid_exp;
  ctrl_t            skid_ctrl;

  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign src_valid = skid_valid | accept;
  assign src_mant  = skid_valid ? skid_mant : in_mant;
  assign src_exp   = skid_valid ? skid_exp  : in_exp;
  assign src_ctrl  = skid_valid ? skid_ctrl : in_ctrl;

  // Skid fills when a beat is accepted while S1 is blocked, drains when S1 advances
  always_comb begin
    skid_valid_nxt = skid_valid;
    if (skid_valid && s1_adv)
      skid_valid_nxt = 1'b0;
    else if (!skid_valid && accept && !s1_adv)
      skid_valid_nxt = 1'b1;
  end

  // Skid storage and registered ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      skid_mant  <= '0;
      skid_exp   <= '0;
      skid_ctrl  <= '0;
    end else begin
      skid_valid <= skid_valid_nxt;
      in_ready_q <= ~skid_valid_nxt;
      if (accept && !s1_adv) begin
        skid_mant <= in_mant;
        skid_exp  <= in_exp;
        skid_ctrl <= in_ctrl;
      end
    end
  end
`else
  assign in_ready  = s1_adv;
  assign accept    = in_valid & s1_adv;
  assign src_valid = accept;
  assign src_mant  = in_mant;
  assign src_exp   = in_exp;
  assign src_ctrl  = in_ctrl;
`endif

  // S1: capture the incoming beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_ctrl  <= '0;
    end else if (s1_adv) begin
      s1_valid <= src_valid;
      if (src_valid) begin
        s1_mant <= src_mant;
        s1_exp  <= src_exp;
        s1_ctrl <= src_ctrl;
      end
    end
  end

  logic inc, nx;

  round_incr_fp u_incr (
    .sign    (s1_ctrl.sign),
    .lsb     (s1_mant[0]),
    .grs     (s1_ctrl.grs),
    .rm      (s1_ctrl.rm),
    .inc     (inc),
    .inexact (nx)
  );

  logic [MAN_W:0]   m_rnd;
  logic [XE_W-1:0]  exp_fin;
  logic             ovf;
  logic [31:0]      res_nxt;
  logic [4:0]       flags_nxt;

  // Round, renormalize on carry, detect overflow/underflow and pack
  always_comb begin
    m_rnd   = {1'b0, s1_mant} + (MAN_W+1)'(inc);
    exp_fin = {1'b0, s1_exp};
    if (m_rnd[MAN_W])
      exp_fin = (s1_exp == '0) ? XE_W'(1) : exp_fin + XE_W'(1);
    ovf = (exp_fin >= XE_W'(EXP_MAX));

    flags_nxt           = '0;
    flags_nxt[FFLAG_NX] = nx | ovf;
    flags_nxt[FFLAG_OF] = ovf;
    flags_nxt[FFLAG_UF] = nx & (exp_fin == '0);
    flags_nxt[FFLAG_DZ] = 1'b0;

    res_nxt = {s1_ctrl.sign, exp_fin[PEXP_W-1:0], m_rnd[MAN_W-1:0]};
    if (ovf) begin
      case (s1_ctrl.rm)
        RM_RTZ:  res_nxt = {s1_ctrl.sign, FP32_MAX[30:0]};
        RM_RDN:  res_nxt = s1_ctrl.sign ? {1'b1, FP32_INF[30:0]} : {1'b0, FP32_MAX[30:0]};
        RM_RUP:  res_nxt = s1_ctrl.sign ? {1'b1, FP32_MAX[30:0]} : {1'b0, FP32_INF[30:0]};
        default: res_nxt = {s1_ctrl.sign, FP32_INF[30:0]};
      endcase
    end

    if (s1_ctrl.special) begin
      res_nxt             = s1_ctrl.special_val;
      flags_nxt           = '0;
      flags_nxt[FFLAG_NV] = s1_ctrl.special_nv;
    end
  end

  // S2: registered result, held while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_fflags <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_nxt;
        out_fflags <= flags_nxt;
      end
    end
  end

endmodule

// File: tb/tb_round_pack_fp_r4.sv
// tb_round_pack_fp_r4: self-checking bench for round_pack_fp_r4 (directed vectors,
// randomized stream against a magnitude-arithmetic reference, backpressure, reset).
module tb_round_pack_fp_r4;

`ifdef FP_ROUND_SKID_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 2;
`endif

  typedef struct packed {
    logic        sign;
    logic [22:0] mant;
    logic [9:0]  exp;
    logic [2:0]  grs;
    logic        uf;
    logic [2:0]  rm;
    logic        special;
    logic [31:0] sval;
    logic        snv;
  } beat_t;

  typedef struct packed {
    beat_t       b;
    logic [31:0] res;
    logic [4:0]  ff;
  } vec_t;

  logic        clk, reset;
  logic        in_valid, in_ready, in_sign, in_underflow, in_special, in_special_nv;
  logic [22:0] in_mant;
  logic [9:0]  in_exp;
  logic [2:0]  in_grs, in_rm;
  logic [31:0] in_special_val;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_fflags;

  int n_cmp = 0;
  int n_mis = 0;

  round_pack_fp_r4 dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_mant(in_mant), .in_exp(in_exp), .in_grs(in_grs),
    .in_underflow(in_underflow), .in_rm(in_rm),
    .in_special(in_special), .in_special_val(in_special_val), .in_special_nv(in_special_nv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_fflags(out_fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: treat {exp,mant} as one magnitude integer; a round-up increment
  // carries naturally into the exponent field.
  function automatic logic [36:0] model(input beat_t b);
    longint      mag;
    int          frac;
    bit          up, nx, of, uf, away;
    logic [31:0] res;
    if (b.special) return {b.snv, 4'b0000, b.sval};
    frac = int'(b.grs);
    nx   = (frac != 0);
    case (b.rm)
      3'd1:    up = 1'b0;
      3'd2:    up = b.sign && nx;
      3'd3:    up = !b.sign && nx;
      3'd4:    up = (frac >= 4);
      default: up = (frac > 4) || (frac == 4 && b.mant[0]);
    endcase
    mag = (longint'(b.exp) << 23) + longint'(b.mant) + longint'(up);
    of  = (mag >= (longint'(255) << 23));
    if (of) begin
      case (b.rm)
        3'd1:    away = 1'b0;
        3'd2:    away = b.sign;
        3'd3:    away = !b.sign;
        default: away = 1'b1;
      endcase
      res = away ? {b.sign, 31'h7F80_0000} : {b.sign, 31'h7F7F_FFFF};
      nx  = 1'b1;
    end else begin
      res = {b.sign, 31'(mag)};
    end
    uf = nx && ((mag >> 23) == 0);
    return {1'b0, 1'b0, of, uf, nx, res};
  endfunction

  function automatic beat_t mk(input logic s, input logic [22:0] m, input logic [9:0] e,
                               input logic [2:0] g, input logic [2:0] rm);
    beat_t b;
    b = '0;
    b.sign = s; b.mant = m; b.exp = e; b.grs = g; b.rm = rm;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b = '0;
    b.sign = 1'($urandom());
    case ($urandom_range(0, 3))
      0:       b.mant = 23'h7F_FFFF;
      1:       b.mant = 23'h00_0000;
      default: b.mant = 23'($urandom());
    endcase
    case ($urandom_range(0, 9))
      0:       b.exp = 10'd0;
      1:       b.exp = 10'd1;
      2:       b.exp = 10'd253;
      3:       b.exp = 10'd254;
      4:       b.exp = 10'd255;
      5:       b.exp = 10'd300;
      default: b.exp = 10'($urandom_range(1, 254));
    endcase
    b.grs     = 3'($urandom());
    b.uf      = (b.exp == 10'd0) ? 1'($urandom()) : 1'b0;
    b.rm      = 3'($urandom_range(0, 7));
    b.special = ($urandom_range(0, 15) == 0);
    b.sval    = 32'($urandom());
    b.snv     = 1'($urandom());
    return b;
  endfunction

  task automatic drive(input beat_t b, input logic v);
    in_valid       = v;
    in_sign        = b.sign;
    in_mant        = b.mant;
    in_exp         = b.exp;
    in_grs         = b.grs;
    in_underflow   = b.uf;
    in_rm          = b.rm;
    in_special     = b.special;
    in_special_val = b.sval;
    in_special_nv  = b.snv;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    drive('0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_mis++; $display("FAIL reset_out_result: got %h expected 00000000", out_result); end
    n_cmp++; if (out_fflags !== 5'h0) begin n_mis++; $display("FAIL reset_out_fflags: got %b expected 00000", out_fflags); end
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[14];
    v[0]  = '{b: mk(0, 23'h000001, 10'd127, 3'b100, 3'd0), res: 32'h3F80_0002, ff: 5'b00001};
    v[1]  = '{b: mk(0, 23'h000002, 10'd127, 3'b100, 3'd0), res: 32'h3F80_0002, ff: 5'b00001};
    v[2]  = '{b: mk(0, 23'h7FFFFF, 10'd127, 3'b110, 3'd0), res: 32'h4000_0000, ff: 5'b00001};
    v[3]  = '{b: mk(0, 23'h7FFFFF, 10'd254, 3'b100, 3'd0), res: 32'h7F80_0000, ff: 5'b00101};
    v[4]  = '{b: mk(0, 23'h7FFFFF, 10'd255, 3'b100, 3'd1), res: 32'h7F7F_FFFF, ff: 5'b00101};
    v[5]  = '{b: mk(1, 23'h7FFFFF, 10'd255, 3'b100, 3'd2), res: 32'hFF80_0000, ff: 5'b00101};
    v[6]  = '{b: mk(0, 23'h7FFFFF, 10'd0,   3'b100, 3'd0), res: 32'h0080_0000, ff: 5'b00001};
    v[7]  = '{b: mk(0, 23'h000001, 10'd0,   3'b010, 3'd1), res: 32'h0000_0001, ff: 5'b00011};
    v[8]  = '{b: mk(0, 23'h000000, 10'd0,   3'b000, 3'd0), res: 32'h7FC0_0000, ff: 5'b10000};
    v[8].b.special = 1'b1; v[8].b.sval = 32'h7FC0_0000; v[8].b.snv = 1'b1;
    v[9]  = '{b: mk(0, 23'h000005, 10'd0,   3'b000, 3'd0), res: 32'h0000_0005, ff: 5'b00000};
    v[9].b.uf = 1'b1;
    v[10] = '{b: mk(0, 23'h000001, 10'd127, 3'b100, 3'd5), res: 32'h3F80_0002, ff: 5'b00001};
    v[11] = '{b: mk(1, 23'h7FFFFF, 10'd255, 3'b001, 3'd3), res: 32'hFF7F_FFFF, ff: 5'b00101};
    v[12] = '{b: mk(0, 23'h000002, 10'd127, 3'b100, 3'd4), res: 32'h3F80_0003, ff: 5'b00001};
    v[13] = '{b: mk(1, 23'h123456, 10'd100, 3'b001, 3'd3), res: 32'hB212_3456, ff: 5'b00001};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(v[i].b, 1'b1);
      @(negedge clk);
      drive('0, 1'b0);
      n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL dir%0d_early_valid: got %b expected 0", i, out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL dir%0d_valid: got %b expected 1", i, out_valid); end
      n_cmp++; if (out_result !== v[i].res) begin n_mis++; $display("FAIL dir%0d_result: got %h expected %h", i, out_result, v[i].res); end
      n_cmp++; if (out_fflags !== v[i].ff) begin n_mis++; $display("FAIL dir%0d_fflags: got %b expected %b", i, out_fflags, v[i].ff); end
    end
  endtask

  task automatic test_random();
    logic [36:0] sb[$];
    logic [36:0] e, held;
    bit          hold;
    beat_t       b;
    logic        v;
    hold = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      b = rand_beat();
      v = (cyc < 440) && ($urandom_range(0, 9) < 7);
      drive(b, v);
      out_ready = (cyc >= 440) || ($urandom_range(0, 9) < 6);
      #1;
      if (hold) begin
        n_cmp++;
        if (!out_valid || {out_fflags, out_result} !== held) begin
          n_mis++; $display("FAIL rnd_hold: got v=%b %h expected v=1 %h", out_valid, {out_fflags, out_result}, held);
        end
      end
      hold = out_valid && !out_ready;
      held = {out_fflags, out_result};
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++; $display("FAIL rnd_spurious: got %h expected no beat", {out_fflags, out_result});
        end else begin
          e = sb.pop_front();
          if ({out_fflags, out_result} !== e) begin
            n_mis++; $display("FAIL rnd_beat: got ff=%b res=%h expected ff=%b res=%h", out_fflags, out_result, e[36:32], e[31:0]);
          end
        end
      end
      if (v && in_ready) sb.push_back(model(b));
    end
    n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL rnd_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    beat_t       bs[5];
    logic [36:0] sb[$];
    logic [36:0] e, held;
    bit          have_held;
    int          idx, acc, got;
    logic        last_ready;
    idx = 0; acc = 0; got = 0; have_held = 1'b0; held = '0; last_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bs[i] = rand_beat();
      bs[i].special = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(bs[idx], 1'b1);
      out_ready = 1'b0;
      #1;
      if (out_valid) begin
        if (have_held) begin
          n_cmp++;
          if ({out_fflags, out_result} !== held) begin
            n_mis++; $display("FAIL bp_hold: got %h expected %h", {out_fflags, out_result}, held);
          end
        end else begin
          held = {out_fflags, out_result}; have_held = 1'b1;
        end
      end
      last_ready = in_ready;
      if (in_ready) begin sb.push_back(model(bs[idx])); idx++; acc++; end
    end
    n_cmp++; if (acc != CAP) begin n_mis++; $display("FAIL bp_capacity: got %0d expected %0d", acc, CAP); end
    n_cmp++; if (last_ready !== 1'b0) begin n_mis++; $display("FAIL bp_in_ready: got %b expected 0", last_ready); end
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if (idx < 5) drive(bs[idx], 1'b1); else drive('0, 1'b0);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        got++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++; $display("FAIL bp_extra: got %h expected no beat", {out_fflags, out_result});
        end else begin
          e = sb.pop_front();
          if ({out_fflags, out_result} !== e) begin
            n_mis++; $display("FAIL bp_order: got %h expected %h", {out_fflags, out_result}, e);
          end
        end
      end
      if (idx < 5 && in_ready) begin sb.push_back(model(bs[idx])); idx++; end
    end
    @(negedge clk);
    drive('0, 1'b0);
    n_cmp++; if (got != 5 || out_valid !== 1'b0) begin n_mis++; $display("FAIL bp_count: got %0d valid=%b expected 5 valid=0", got, out_valid); end
  endtask

  task automatic test_reset_midstream();
    beat_t b;
    logic [36:0] e;
    b = mk(0, 23'h000001, 10'd127, 3'b100, 3'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(b, 1'b1);
    end
    @(negedge clk);
    drive('0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_fflags !== 5'b00001) begin n_mis++; $display("FAIL mid_pre: got v=%b ff=%b expected v=1 ff=00001", out_valid, out_fflags); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_fflags !== 5'b0) begin n_mis++; $display("FAIL mid_async_fflags: got %b expected 00000", out_fflags); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    b = mk(1, 23'h400000, 10'd130, 3'b101, 3'd0);
    e = model(b);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_mis++; $display("FAIL post_reset_idle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
    drive(b, 1'b1);
    @(negedge clk);
    drive('0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL post_reset_lat1: got %b expected 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || {out_fflags, out_result} !== e) begin n_mis++; $display("FAIL post_reset_lat2: got v=%b %h expected v=1 %h", out_valid, {out_fflags, out_result}, e); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
